// File: rtl/spatial_hv_mem_responder.sv
// SRAM-side responder for one spatial-encoder modality: word-serial load of three HV banks, then 1-cycle registered row reads.
// Optional even-parity protection per row is enabled by defining HVMEM_PARITY_EN.
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif

module spatial_hv_mem_responder #(
  parameter int HV_DIMENSION = `HV_DIMENSION,
  parameter int DEPTH        = 32,
  parameter int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    LoadValid_SI,
  output logic                    LoadReady_SO,
  input  logic [31:0]             LoadData_DI,
  input  logic                    Reload_SI,
  output logic                    LoadDone_SO,
  input  logic                    ReqValid_SI,
  input  logic                    ReqReady_SI,
  input  logic [AW-1:0]           Addr_DI,
  output logic                    DataReady_SO,
  output logic                    DataValid_SO,
  output logic [0:HV_DIMENSION-1] IMOut_DO,
  output logic [0:HV_DIMENSION-1] ProjNeg_DO,
  output logic [0:HV_DIMENSION-1] ProjPos_DO,
  output logic                    ParityErr_SO
);
  localparam int WORDS = (HV_DIMENSION + 31) / 32;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW    = (HV_DIMENSION > 1) ? $clog2(HV_DIMENSION) : 1;

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  typedef logic [0:HV_DIMENSION-1] row_t;

  logic [0:0]    state_q, state_d;
  logic [WW-1:0] word_q, word_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    bank_q, bank_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          latch_v_q, latch_v_d;
  row_t          im_out_q, im_out_d, neg_out_q, neg_out_d, pos_out_q, pos_out_d;

  row_t im_mem_q  [DEPTH];
  row_t neg_mem_q [DEPTH];
  row_t pos_mem_q [DEPTH];

  logic          in_load, in_serve, load_fire, req_fire, rd_fire;
  logic          last_word, last_row, last_bank;
  logic [RW-1:0] rd_row;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    in_load   = (state_q == ST_LOAD);
    in_serve  = (state_q == ST_SERVE);
    load_fire = in_load & ~Reload_SI & LoadValid_SI;
    last_word = (word_q == WW'(WORDS - 1));
    last_row  = (row_q == RW'(DEPTH - 1));
    last_bank = (bank_q == 2'd2);
    req_fire  = in_serve & ~Reload_SI & ReqValid_SI & ReqReady_SI;
    rd_fire   = req_fire & (32'(Addr_DI) < 32'(DEPTH));
    rd_row    = RW'(Addr_DI);

    state_d = state_q;
    word_d  = word_q;
    row_d   = row_q;
    bank_d  = bank_q;
    if (Reload_SI) begin
      // Reload wins over a coinciding beat; stored rows are left untouched.
      state_d = ST_LOAD;
      word_d  = '0;
      row_d   = '0;
      bank_d  = '0;
    end else if (load_fire) begin
      word_d = last_word ? '0 : word_q + WW'(1);
      if (last_word) begin
        row_d = last_row ? '0 : row_q + RW'(1);
        if (last_row) begin
          bank_d = last_bank ? 2'd0 : bank_q + 2'd1;
          if (last_bank) state_d = ST_SERVE;
        end
      end
    end

    addr_d    = req_fire ? Addr_DI : addr_q;
    latch_v_d = rd_fire;
    im_out_d  = rd_fire ? im_mem_q[rd_row]  : im_out_q;
    neg_out_d = rd_fire ? neg_mem_q[rd_row] : neg_out_q;
    pos_out_d = rd_fire ? pos_mem_q[rd_row] : pos_out_q;
  end

  always_ff @(posedge Clk_CI) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Reset_RI) begin
      state_q   <= ST_LOAD;
      word_q    <= '0;
      row_q     <= '0;
      bank_q    <= '0;
      addr_q    <= '0;
      latch_v_q <= 1'b0;
      im_out_q  <= '0;
      neg_out_q <= '0;
      pos_out_q <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      row_q     <= row_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      latch_v_q <= latch_v_d;
      im_out_q  <= im_out_d;
      neg_out_q <= neg_out_d;
      pos_out_q <= pos_out_d;
    end
  end

  // NOTE: the banks are storage, not control state; they are never reset so rows survive Reset_RI.
  always_ff @(posedge Clk_CI) begin
    if (load_fire && !Reset_RI) begin
      for (int b = 0; b < 32; b++) begin
        if (int'(word_q) * 32 + b < HV_DIMENSION) begin
          case (bank_q)
            2'd0:    im_mem_q[row_q][BW'(int'(word_q) * 32 + b)]  <= LoadData_DI[5'(31 - b)];
            2'd1:    neg_mem_q[row_q][BW'(int'(word_q) * 32 + b)] <= LoadData_DI[5'(31 - b)];
            default: pos_mem_q[row_q][BW'(int'(word_q) * 32 + b)] <= LoadData_DI[5'(31 - b)];
          endcase
        end
      end
    end
  end

`ifdef HVMEM_PARITY_EN
  localparam int          LAST_BITS = HV_DIMENSION - 32 * (WORDS - 1);
  localparam logic [31:0] LAST_MASK = ~(32'hFFFF_FFFF >> LAST_BITS);

  logic       par_acc_q, par_acc_d, row_par;
  logic       par_pend_q, par_pend_d;
  logic [2:0] par_exp_q, par_exp_d;
  logic       par_err_q, par_err_d;
  logic       par_im_q [DEPTH];
  logic       par_neg_q [DEPTH];
  logic       par_pos_q [DEPTH];

  always_comb begin
    // Only bits that land inside the row take part in its parity.
    row_par   = par_acc_q ^ (^(LoadData_DI & (last_word ? LAST_MASK : 32'hFFFF_FFFF)));
    par_acc_d = par_acc_q;
    if (Reload_SI)      par_acc_d = 1'b0;
    else if (load_fire) par_acc_d = last_word ? 1'b0 : row_par;
    par_pend_d = rd_fire;
    par_exp_d  = rd_fire ? {par_pos_q[rd_row], par_neg_q[rd_row], par_im_q[rd_row]} : par_exp_q;
    par_err_d  = Reload_SI ? 1'b0
               : par_err_q | (par_pend_q & (|({^pos_out_q, ^neg_out_q, ^im_out_q} ^ par_exp_q)));
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      par_acc_q  <= 1'b0;
      par_pend_q <= 1'b0;
      par_exp_q  <= '0;
      par_err_q  <= 1'b0;
    end else begin
      par_acc_q  <= par_acc_d;
      par_pend_q <= par_pend_d;
      par_exp_q  <= par_exp_d;
      par_err_q  <= par_err_d;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (load_fire && last_word && !Reset_RI) begin
      case (bank_q)
        2'd0:    par_im_q[row_q]  <= row_par;
        2'd1:    par_neg_q[row_q] <= row_par;
        default: par_pos_q[row_q] <= row_par;
      endcase
    end
  end

  assign ParityErr_SO = par_err_q;
`else
  assign ParityErr_SO = 1'b0;
`endif

  assign LoadReady_SO = in_load & ~Reload_SI;
  assign LoadDone_SO  = in_serve;
  assign DataReady_SO = in_serve;
  assign DataValid_SO = in_serve & ReqValid_SI & latch_v_q & (addr_q == Addr_DI);
  assign IMOut_DO     = im_out_q;
  assign ProjNeg_DO   = neg_out_q;
  assign ProjPos_DO   = pos_out_q;

endmodule

// File: tb/tb_spatial_hv_mem_responder.sv
// Directed bench for spatial_hv_mem_responder: table-driven serve vectors plus hand-written load/reload/parity sequences.
`timescale 1ns/1ps

module tb_spatial_hv_mem_responder;
  localparam int HV    = 2000;
  localparam int DEPTH = 32;
  localparam int AW    = 6;
  localparam int WORDS = 63;
  localparam int TOTAL = 3 * DEPTH * WORDS;

  logic          clk = 1'b0;
  logic          rst, load_valid, load_ready, reload, load_done;
  logic          req_valid, req_ready, data_ready, data_valid, parity_err;
  logic [31:0]   load_data;
  logic [AW-1:0] addr;
  logic [0:HV-1] im_out, neg_out, pos_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spatial_hv_mem_responder #(.HV_DIMENSION(HV), .DEPTH(DEPTH), .AW(AW)) dut (
    .Clk_CI(clk), .Reset_RI(rst),
    .LoadValid_SI(load_valid), .LoadReady_SO(load_ready), .LoadData_DI(load_data),
    .Reload_SI(reload), .LoadDone_SO(load_done),
    .ReqValid_SI(req_valid), .ReqReady_SI(req_ready), .Addr_DI(addr),
    .DataReady_SO(data_ready), .DataValid_SO(data_valid),
    .IMOut_DO(im_out), .ProjNeg_DO(neg_out), .ProjPos_DO(pos_out),
    .ParityErr_SO(parity_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          valid;
    logic          ready;
    logic          exp_dv;
    logic [31:0]   exp_im;
    logic [31:0]   exp_neg;
    logic [31:0]   exp_pos;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wk(input logic [0:HV-1] r, input int k);
    return r[k*32 +: 32];
  endfunction

  function automatic vec_t mk(input int a, input logic v, input logic r, input logic dv,
                              input int im, input int ng, input int ps);
    vec_t t;
    t.addr = AW'(a); t.valid = v; t.ready = r; t.exp_dv = dv;
    t.exp_im = 32'(im); t.exp_neg = 32'(ng); t.exp_pos = 32'(ps);
    return t;
  endfunction

  // Loads all three banks with word value = global beat index.
  task automatic load_all();
    int not_ready;
    not_ready = 0;
    for (int g = 0; g < TOTAL; g++) begin
      load_valid = 1'b1;
      load_data  = 32'(g);
      @(negedge clk);
      if (!load_ready) not_ready++;
      if (g == TOTAL - 1) check("done_before_last_beat", load_done, 0);
      step();
    end
    load_valid = 1'b0;
    check("load_beats_not_ready", 64'(not_ready), 0);
    @(negedge clk);
    check("load_done_after_last", load_done, 1);
    check("load_ready_in_serve", load_ready, 0);
    check("data_ready_in_serve", data_ready, 1);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles, hi_count;
    logic got;
    logic [31:0] exp3;
    logic exp_err;

    vecs[0]  = mk(0, 1, 1, 0,   0,    0,    0);
    vecs[1]  = mk(0, 1, 1, 1,   0, 2016, 4032);
    vecs[2]  = mk(1, 1, 1, 0,   0, 2016, 4032);
    vecs[3]  = mk(1, 1, 1, 1,  63, 2079, 4095);
    vecs[4]  = mk(1, 0, 1, 0,  63, 2079, 4095);
    vecs[5]  = mk(1, 1, 1, 0,  63, 2079, 4095);
    vecs[6]  = mk(1, 1, 1, 1,  63, 2079, 4095);
    vecs[7]  = mk(2, 1, 0, 0,  63, 2079, 4095);
    vecs[8]  = mk(2, 1, 0, 0,  63, 2079, 4095);
    vecs[9]  = mk(2, 1, 1, 0,  63, 2079, 4095);
    vecs[10] = mk(2, 1, 1, 1, 126, 2142, 4158);

    rst = 1'b1; load_valid = 1'b0; load_data = '0; reload = 1'b0;
    req_valid = 1'b0; req_ready = 1'b0; addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d_load_ready", i), load_ready, 1);
      check($sformatf("idle%0d_load_done", i), load_done, 0);
      check($sformatf("idle%0d_data_valid", i), data_valid, 0);
      check($sformatf("idle%0d_data_ready", i), data_ready, 0);
      check($sformatf("idle%0d_parity_err", i), parity_err, 0);
      check($sformatf("idle%0d_im_w0", i), wk(im_out, 0), 0);
      step();
    end

    // Three beats, then a reload coinciding with a beat that must be dropped.
    for (int g = 0; g < 3; g++) begin
      load_valid = 1'b1; load_data = 32'(g);
      step();
    end
    reload = 1'b1; load_data = 32'd999;
    @(negedge clk);
    check("reload_beat_ready", load_ready, 0);
    step();
    reload = 1'b0; load_valid = 1'b0;

    load_all();

    for (int i = 0; i < 11; i++) begin
      addr = vecs[i].addr; req_valid = vecs[i].valid; req_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("vec%0d_dv", i), data_valid, vecs[i].exp_dv);
      check($sformatf("vec%0d_im", i), wk(im_out, 0), vecs[i].exp_im);
      check($sformatf("vec%0d_neg", i), wk(neg_out, 0), vecs[i].exp_neg);
      check($sformatf("vec%0d_pos", i), wk(pos_out, 0), vecs[i].exp_pos);
      step();
    end

    req_valid = 1'b0;
    step();

    // Encoder-style sweep: advance the address whenever DataValid_SO is seen.
    req_valid = 1'b1; req_ready = 1'b1; cycles = 0;
    for (int a = 0; a < DEPTH; a++) begin
      addr = AW'(a);
      got = 1'b0;
      for (int w = 0; w < 4 && !got; w++) begin
        @(negedge clk);
        cycles++;
        if (data_valid) got = 1'b1;
        else step();
      end
      check($sformatf("sweep%0d_dv", a), got, 1);
      check($sformatf("sweep%0d_im_w0", a), wk(im_out, 0), 64'(63 * a));
      check($sformatf("sweep%0d_im_w3", a), wk(im_out, 3), 64'(63 * a + 3));
      check($sformatf("sweep%0d_im_w61", a), wk(im_out, 61), 64'(63 * a + 61));
      check($sformatf("sweep%0d_pos_w0", a), wk(pos_out, 0), 64'(4032 + 63 * a));
      step();
    end
    check("sweep_cycles", 64'(cycles), 64);
    @(negedge clk);
    check("sweep_parity_err", parity_err, 0);
    step();

    // Hold addr 5 with a three-cycle valid gap.
    addr = 6'd5;
    @(negedge clk); check("hold5_first_dv", data_valid, 0); step();
    @(negedge clk); check("hold5_dv", data_valid, 1); check("hold5_im", wk(im_out, 0), 315); step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("gap%0d_dv", i), data_valid, 0);
      check($sformatf("gap%0d_im", i), wk(im_out, 0), 315);
      step();
    end
    req_valid = 1'b1;
    @(negedge clk); check("reassert_dv0", data_valid, 0); step();
    @(negedge clk); check("reassert_dv1", data_valid, 1); check("reassert_im", wk(im_out, 0), 315); step();

    // Out-of-range address stalls the encoder.
    addr = 6'd40; hi_count = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (data_valid) hi_count++;
      step();
    end
    check("oor_dv_high_cycles", 64'(hi_count), 0);
    check("oor_data_held", wk(im_out, 0), 315);
    check("oor_data_ready", data_ready, 1);

    // Reload in SERVE.
    addr = 6'd5;
    step();
    @(negedge clk); check("pre_reload_dv", data_valid, 1);
    reload = 1'b1;
    #1;
    check("reload_cycle_dv", data_valid, 1);
    step();
    reload = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("after_reload_dv", data_valid, 0);
    check("after_reload_done", load_done, 0);
    check("after_reload_load_ready", load_ready, 1);
    check("after_reload_data_ready", data_ready, 0);
    step();

    load_all();

`ifdef HVMEM_PARITY_EN
    dut.im_mem_q[3][7] = ~dut.im_mem_q[3][7];
    exp3 = 32'd189 ^ 32'h0100_0000;
    exp_err = 1'b1;
`else
    exp3 = 32'd189;
    exp_err = 1'b0;
`endif
    addr = 6'd3; req_valid = 1'b1; req_ready = 1'b1;
    @(negedge clk); check("par_req_dv", data_valid, 0); check("par_req_err", parity_err, 0); step();
    @(negedge clk); check("par_data_dv", data_valid, 1); check("par_data_im", wk(im_out, 0), 64'(exp3));
    check("par_data_err", parity_err, 0); step();
    @(negedge clk); check("par_err_set", parity_err, exp_err); step();
    req_valid = 1'b0;
    @(negedge clk); check("par_err_sticky", parity_err, exp_err);
    reload = 1'b1;
    step();
    reload = 1'b0;
    @(negedge clk); check("par_err_cleared", parity_err, 0); check("par_reload_done", load_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
